robot_motion_sequencer: RTL

ROBOT_MOTION_SEQUENCER -- requirements
Module: robot_motion_sequencer

---
 rtl/robot_pkg.sv | 26 ++
 rtl/step_timer.sv | 26 ++
 rtl/robot_motion_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/robot_pkg.sv
// Shared types and motor-drive encodings for the robot motion sequencer.
package robot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        FWD,
        SETTLE,
        DONE
    } state_t;

    // Motor drive word: {motor_l_en, motor_r_en, motor_l_dir, motor_r_dir}
    localparam logic [3:0] MOTOR_OFF    = 4'b0000;
    localparam logic [3:0] MOTOR_FWD    = 4'b1111;
    localparam logic [3:0] MOTOR_TURN_R = 4'b1110;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module step_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/robot_motion_sequencer.sv
// Executes turn / forward / NOP decisions as timed motor pulses with settle gaps.
// Optional idle watchdog search turn: define ROBOT_CMD_WATCHDOG_EN.
module robot_motion_sequencer
    import robot_pkg::*;
#(
    parameter int FWD_CYCLES    = 8,
    parameter int TURN_CYCLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int WDOG_CYCLES   = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  logic cmd_front,
    input  logic cmd_turn,
    input  logic obstacle,
    output logic motor_l_en,
    output logic motor_r_en,
    output logic motor_l_dir,
    output logic motor_r_dir,
    output logic busy,
    output logic step_done,
    output logic aborted,
    output logic wdog_timeout
);

    localparam int CNT_W = $clog2(max4(FWD_CYCLES, TURN_CYCLES, SETTLE_CYCLES, WDOG_CYCLES) + 1);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_motor;
    logic [3:0]       w_motor;
    logic             r_cmd_ready;
    logic             r_busy;
    logic             r_step_done;
    logic             r_aborted;
    logic             r_wdog_timeout;
    logic             r_fwd_pending;
    logic             w_accept;
    logic             w_abort;
    logic             w_dur_zero;
    logic             w_dur_load;
    logic [CNT_W-1:0] w_dur_value;
    logic             w_wd_fire;

    assign w_accept = cmd_valid && r_cmd_ready;
    assign w_abort  = (r_state == FWD) && obstacle;

    always_comb begin
        w_next      = r_state;
        w_motor     = MOTOR_OFF;
        w_dur_value = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (cmd_turn)       w_next = TURN;
                    else if (cmd_front) w_next = FWD;
                    else                w_next = DONE;
                end else if (w_wd_fire) begin
                    w_next = TURN;
                end
            end
            TURN:    if (w_dur_zero) w_next = SETTLE;
            FWD:     if (obstacle || w_dur_zero) w_next = SETTLE;
            SETTLE:  if (w_dur_zero) w_next = r_fwd_pending ? FWD : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        case (w_next)
            TURN: begin
                w_motor     = MOTOR_TURN_R;
                w_dur_value = CNT_W'(TURN_CYCLES - 1);
            end
            FWD: begin
                w_motor     = MOTOR_FWD;
                w_dur_value = CNT_W'(FWD_CYCLES - 1);
            end
            SETTLE:  w_dur_value = CNT_W'(SETTLE_CYCLES - 1);
            default: w_dur_value = '0;
        endcase
    end

    // Every timed state is entered through a state change, so that is the reload point.
    assign w_dur_load = (w_next != r_state);

    step_timer #(.W(CNT_W)) u_dur_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_dur_load),
        .i_value (w_dur_value),
        .o_zero  (w_dur_zero)
    );

`ifdef ROBOT_CMD_WATCHDOG_EN
    logic             r_wd_armed;
    logic             w_wd_zero;
    logic             w_wd_load;
    logic [CNT_W-1:0] w_wd_value;

    // The first idle cycle after reset arms the counter, so it loads one less to keep the count exact.
    assign w_wd_load  = (r_state != IDLE) || !r_wd_armed;
    assign w_wd_value = r_wd_armed ? CNT_W'(WDOG_CYCLES - 1)
                                   : CNT_W'((WDOG_CYCLES >= 2) ? WDOG_CYCLES - 2 : 0);
    assign w_wd_fire  = (r_state == IDLE) && !w_accept
                        && (r_wd_armed ? w_wd_zero : (WDOG_CYCLES == 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wd_armed <= 1'b0;
        else        r_wd_armed <= 1'b1;
    end

    step_timer #(.W(CNT_W)) u_wdog_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_wd_load),
        .i_value (w_wd_value),
        .o_zero  (w_wd_zero)
    );
`else
    assign w_wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_motor        <= MOTOR_OFF;
            r_cmd_ready    <= 1'b0;
            r_busy         <= 1'b0;
            r_step_done    <= 1'b0;
            r_aborted      <= 1'b0;
            r_wdog_timeout <= 1'b0;
            r_fwd_pending  <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_motor        <= w_motor;
            r_cmd_ready    <= (w_next == IDLE);
            r_busy         <= (w_next != IDLE);
            r_step_done    <= (w_next == DONE);
            r_aborted      <= w_abort;
            r_wdog_timeout <= w_wd_fire;
            if (w_accept)
                r_fwd_pending <= cmd_turn && cmd_front;
            else if (w_abort || (r_state == SETTLE && w_next == FWD))
                r_fwd_pending <= 1'b0;
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign busy         = r_busy;
    assign step_done    = r_step_done;
    assign aborted      = r_aborted;
    assign wdog_timeout = r_wdog_timeout;
    assign motor_l_en   = r_motor[3];
    assign motor_r_en   = r_motor[2];
    assign motor_l_dir  = r_motor[1];
    assign motor_r_dir  = r_motor[0];

endmodule
